// File: rtl/ndata_stream_arbiter.sv
// ndata_stream_arbiter: round-robin packet-atomic arbiter, NUM_REQ in_* streams (valid/ready/last/keep) onto one registered out_* stream tagged with out_id; NDATA_ARB_STATS_EN adds per-requester pkt_cnt
module ndata_stream_arbiter #(
  parameter type data_t = logic [31:0],
  parameter int NUM_ELEMENTS = 4,
  parameter int NUM_REQ = 4,
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic clk,
  input  logic rst,
  input  data_t [NUM_REQ-1:0][NUM_ELEMENTS-1:0] in_data,
  input  logic [NUM_REQ-1:0][NUM_ELEMENTS-1:0] in_keep,
  input  logic [NUM_REQ-1:0] in_last,
  input  logic [NUM_REQ-1:0] in_valid,
  output logic [NUM_REQ-1:0] in_ready,
  output data_t [NUM_ELEMENTS-1:0] out_data,
  output logic [NUM_ELEMENTS-1:0] out_keep,
  output logic out_last,
  output logic out_valid,
  input  logic out_ready,
  output logic [ID_W-1:0] out_id
`ifdef NDATA_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0] pkt_cnt
`endif
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, grant, winner;
  logic load_en, accept, pkt_end;
  assign load_en = !out_valid || out_ready;
  assign accept = state == LOCK && in_valid[grant] && load_en;
  assign pkt_end = accept && in_last[grant];
  always_comb begin
    winner = rr_ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      automatic int idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (in_valid[idx]) winner = ID_W'(idx);
    end
  end
  always_comb begin
    state_nxt = state == IDLE ? (|in_valid ? LOCK : IDLE) : (pkt_end ? IDLE : LOCK);
    in_ready = (state == LOCK && load_en) ? NUM_REQ'(1) << grant : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      rr_ptr <= ID_W'(NUM_REQ - 1);
      grant <= '0;
      out_id <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |in_valid) grant <= winner;
      if (pkt_end) rr_ptr <= grant;
      if (accept) begin
        out_valid <= 1'b1;
        out_id <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      out_data <= in_data[grant];
      out_keep <= in_keep[grant];
      out_last <= in_last[grant];
    end
  end
`ifdef NDATA_ARB_STATS_EN
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REQ; r++)
      if (rst) pkt_cnt[r] <= '0;
      else if (pkt_end && grant == ID_W'(r)) pkt_cnt[r] <= pkt_cnt[r] + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ndata_stream_arbiter.sv
// tb_ndata_stream_arbiter: randomized + directed checks of ndata_stream_arbiter against a transaction-level model
module tb_ndata_stream_arbiter;
  localparam int N = 4, E = 4;
  typedef struct packed {logic [E-1:0][31:0] data; logic [E-1:0] keep; logic last;} beat_t;
  logic clk = 0, rst = 1;
  logic [N-1:0][E-1:0][31:0] in_data = '0;
  logic [N-1:0][E-1:0] in_keep = '0;
  logic [N-1:0] in_last = '0, in_valid = '0, in_ready;
  logic [E-1:0][31:0] out_data;
  logic [E-1:0] out_keep;
  logic out_last, out_valid, out_ready = 1;
  logic [1:0] out_id;
`ifdef NDATA_ARB_STATS_EN
  logic [N-1:0][31:0] pkt_cnt;
`endif
  int tests = 0, fails = 0;
  beat_t q[N][$];
  beat_t sent[$], obeats[$];
  int ids[$];
  logic [N-1:0] en = '1;
  bit m_busy = 0, m_hold = 0;
  int m_owner = 0, m_prev = N - 1, m_id = 0;
  beat_t m_beat;
  int unsigned m_cnt[N] = '{default: 0};

  ndata_stream_arbiter #(.NUM_ELEMENTS(E), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id)
`ifdef NDATA_ARB_STATS_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [159:0] act, logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One step of the abstract arbiter: who owns the output, what beat it holds, who is next.
  task automatic model_step();
    bit acc;
    if (rst) begin
      m_busy = 0; m_hold = 0; m_prev = N - 1; m_id = 0;
      for (int r = 0; r < N; r++) m_cnt[r] = 0;
      return;
    end
    acc = m_busy && in_valid[m_owner] && (!m_hold || out_ready);
    if (acc) begin
      m_hold = 1;
      m_id = m_owner;
      m_beat = {in_data[m_owner], in_keep[m_owner], in_last[m_owner]};
      if (in_last[m_owner]) begin
        m_busy = 0;
        m_prev = m_owner;
        m_cnt[m_owner]++;
      end
    end else begin
      if (out_ready) m_hold = 0;
      if (!m_busy && in_valid != 0) begin
        m_busy = 1;
        for (int k = 1; k <= N; k++)
          if (in_valid[(m_prev + k) % N]) begin
            m_owner = (m_prev + k) % N;
            break;
          end
      end
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    exp_rdy = (m_busy && (!m_hold || out_ready)) ? N'(1) << m_owner : '0;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_hold);
    check("out_id", out_id, m_id);
    if (m_hold) check("out_beat", {out_data, out_keep, out_last}, m_beat);
`ifdef NDATA_ARB_STATS_EN
    for (int r = 0; r < N; r++) check("pkt_cnt", pkt_cnt[r], m_cnt[r]);
`endif
    if (out_valid && out_ready) begin
      ids.push_back(int'(out_id));
      obeats.push_back({out_data, out_keep, out_last});
    end
    if (!rst) for (int i = 0; i < N; i++) if (in_valid[i] && in_ready[i]) void'(q[i].pop_front());
    model_step();
  end

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = en[i] && q[i].size() > 0;
      if (q[i].size() > 0) {in_data[i], in_keep[i], in_last[i]} = q[i][0];
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    for (int i = 0; i < N; i++) q[i].delete();
    tick();
    rst = 0;
    ids.delete(); obeats.delete(); sent.delete();
  endtask

  task automatic push_pkt(int r, int len);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      for (int e = 0; e < E; e++) x.data[e] = $urandom;
      x.keep = 4'($urandom);
      x.last = (b == len - 1);
      q[r].push_back(x);
      sent.push_back(x);
    end
  endtask

  task automatic wait_ids(int n, string name);
    for (int k = 0; k < 300 && ids.size() < n; k++) tick();
    check(name, ids.size() >= n, 1);
  endtask

  task automatic wait_q(int r, int n);
    for (int k = 0; k < 300 && q[r].size() > n; k++) tick();
    check("wait_q", q[r].size() <= n, 1);
  endtask

  initial begin
    int lat;
    tick(2);
    rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_id", out_id, 0);
    // single requester: 2-cycle latency, 3 back-to-back beats
    push_pkt(2, 3);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    check("t1_latency", lat, 2);
    tick();
    wait_ids(3, "t1_wait");
    for (int b = 0; b < 3 && b < ids.size(); b++) begin
      check("t1_id", ids[b], 2);
      check("t1_beat", obeats[b], sent[b]);
    end
    // all requesters, 2-beat packets: round-robin order from reset
    do_reset();
    for (int p = 0; p < 2; p++) for (int r = 0; r < N; r++) push_pkt(r, 2);
    wait_ids(16, "t2_wait");
    for (int k = 0; k < 10 && k < ids.size(); k++) check("t2_order", ids[k], (k / 2) % N);
    // backpressure on a 4-beat packet from requester 1
    do_reset();
    push_pkt(1, 4);
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    out_ready = 1; tick();
    out_ready = 0; tick();
    out_ready = 0; tick();
    out_ready = 1; tick();
    wait_ids(4, "t3_wait");
    for (int b = 0; b < 4 && b < ids.size(); b++) begin
      check("t3_id", ids[b], 1);
      check("t3_beat", obeats[b], sent[b]);
    end
    check("t3_count", ids.size(), 4);
    // held lock: requester 0 stalls mid-packet, requester 3 must wait
    do_reset();
    push_pkt(0, 2);
    push_pkt(3, 1);
    wait_q(0, 1);
    en[0] = 0;
    tick(5);
    check("t4_held", ids.size(), 1);
    en[0] = 1;
    wait_ids(3, "t4_wait");
    check("t4_seq", {ids[0][7:0], ids[1][7:0], ids[2][7:0]}, 24'h000003);
    // reset mid-packet
    do_reset();
    push_pkt(0, 4);
    wait_q(0, 2);
    do_reset();
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 0);
    push_pkt(1, 1);
    push_pkt(3, 1);
    wait_ids(2, "t5_wait");
    check("t5_seq", {ids[0][7:0], ids[1][7:0]}, 16'h0103);
    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      out_ready = $urandom_range(0, 3) != 0;
      en = N'($urandom);
      for (int r = 0; r < N; r++)
        if (q[r].size() == 0 && $urandom_range(0, 3) == 0) push_pkt(r, $urandom_range(1, 4));
      tick();
    end
    en = '1;
    out_ready = 1;
    tick(100);
    check("t6_drain", obeats.size(), sent.size());
`ifdef NDATA_ARB_STATS_EN
    do_reset();
    for (int p = 0; p < 3; p++) push_pkt(0, 2);
    push_pkt(2, 1);
    tick(60);
    check("st_cnt", {pkt_cnt[0], pkt_cnt[1], pkt_cnt[2], pkt_cnt[3]}, {32'd3, 32'd0, 32'd1, 32'd0});
    force dut.pkt_cnt[0] = 32'hFFFFFFFF;
    m_cnt[0] = 32'hFFFFFFFF;
    tick();
    release dut.pkt_cnt[0];
    push_pkt(0, 1);
    tick(10);
    check("st_wrap", pkt_cnt[0], 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ndata_stream_arbiter.md
Name: ndata_stream_arbiter

Overview:
- Round-robin, packet-atomic arbiter that shares one ndata stream (e.g. the input of the per-element decoupling stage) between NUM_REQ ndata requesters.
- Once a requester is granted, it holds the grant until its beat with last=1 is accepted; only then does the grant rotate.
- The output is registered (one pipeline stage) so the shared datapath sees a clean valid/ready source.

Parameters:
- data_t, logic[31:0]: element type carried in each lane.
- NUM_ELEMENTS, 4: lanes per beat.
- NUM_REQ, 4: number of requesters, ≥1; ID_W = max(1, $clog2(NUM_REQ)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high (one clock; polarity and synchronicity fixed).
- in_data  in  [NUM_REQ][NUM_ELEMENTS] data_t  per-requester beat data.
- in_keep  in  [NUM_REQ][NUM_ELEMENTS]  per-lane keep.
- in_last  in  [NUM_REQ]  end of packet.
- in_valid  in  [NUM_REQ]  beat valid.
- in_ready  out  [NUM_REQ]  beat accepted when in_valid & in_ready.
- out_data  out  [NUM_ELEMENTS] data_t  arbitrated beat.
- out_keep  out  [NUM_ELEMENTS]  keep.
- out_last  out  1  last.
- out_valid  out  1  valid.
- out_ready  in  1  downstream ready.
- out_id  out  ID_W  index of the requester whose beat is on out_*.

Behaviour:
- Reset values: state=IDLE, out_valid=0, rr_ptr=NUM_REQ-1, grant=0, out_id=0, in_ready=0.
  - out_data/out_keep/out_last are don't-care under reset (not reset).
- Reset mid-packet drops the held output beat and the lock. The partially transferred packet is not completed.
- Output register rule: load_en = !out_valid | out_ready.
  - On an accepted input beat, out_* is loaded and out_valid=1.
  - Else, if out_ready, out_valid=0.
  - Else out_* holds stable.
- States:
  - IDLE: in_ready=0. If any in_valid, the winner is the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. Next cycle: grant=winner, state=LOCK. No in_valid → stay IDLE.
  - LOCK: in_ready[grant] = load_en; all others 0.
    - Accepted beat with in_last=1 → rr_ptr=grant, state=IDLE.
    - Accepted beat with in_last=0 → stay LOCK.
- Latency: IDLE with a request present → first beat on out_* 2 cycles later (arbitration bubble).
  - Within a packet, full throughput: 1 beat/cycle while out_ready=1.
  - One idle cycle on the input side between packets.
- Fairness: a requester that keeps in_valid high is served within NUM_REQ packets.
- A granted requester dropping in_valid mid-packet keeps the lock. The arbiter waits indefinitely with no timeout.
- Single-beat packet (last=1 on the first beat): one accepted beat, then return to IDLE.
- NUM_REQ=1: the same FSM applies and out_id is always 0.
- Requests changing while in LOCK have no effect until IDLE.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to in_ready.

Optional Feature:
- Macro: NDATA_ARB_STATS_EN.
- Defined:
  - Adds output port pkt_cnt [NUM_REQ][32].
  - Each counter increments by 1 when its requester's last=1 beat is accepted.
  - Counters wrap at 2^32-1 → 0 and reset to 0.
- Undefined: port and counters absent; behaviour otherwise identical.

Test Plan:
- Single requester: NUM_REQ=4, requester 2 sends a 3-beat packet, out_ready=1.
  - out_valid rises 2 cycles after in_valid.
  - Beats appear consecutively with out_id=2 and last only on beat 3.
  - Then IDLE for 1 cycle.
- All 4 requesters valid continuously with 2-beat packets, from reset.
  - Grant order is 0,1,2,3,0.
  - Packets are never interleaved; the out_id sequence is 0,0,1,1,2,2,3,3,0,0.
- Backpressure: out_ready toggles 1,0,0,1 during a 4-beat packet from requester 1.
  - out_* stays stable while out_valid=1 and out_ready=0.
  - in_ready[1]=0 in those cycles; no beat is lost or duplicated; keep is preserved per lane.
- Held lock: requester 0 sends beat 1 (last=0), drops in_valid for 5 cycles while requester 3 is valid.
  - Requester 3 is not granted until requester 0's last beat is accepted.
- Reset mid-packet: rst=1 for 1 cycle after beat 2 of 4.
  - Next cycle out_valid=0, state IDLE, rr_ptr=3.
  - A new request from requester 1 then wins first.
- NDATA_ARB_STATS_EN defined: requester 0 sends 3 packets and requester 2 sends 1.
  - Final pkt_cnt = {3,0,1,0}.
  - A counter preloaded via force to 32'hFFFFFFFF wraps to 0 on the next packet.
